mem_split_lsu: RTL and testbench
================================

# mem_split_lsu

Parametrised load/store unit for the memory stage of the RV64 pipeline. It replaces direct single-cycle memory-port wiring with a valid/ready bus master. It performs byte-lane alignment, write-strobe generation and load sign/zero extension. Accesses that cross a bus-word boundary are split into two bus beats and merged. The pipeline stalls on `req_ready`/`resp_valid`, and the block reports unsupported accesses as errors instead of issuing them.

## Interface
Parameters:
- `DATA_W`, 64: bus data width; legal values 32 or 64. NB = DATA_W/8 bytes per beat.
- `ADDR_W`, 64: address width.
- `ALLOW_MISALIGN`, 1: 1 = boundary-crossing accesses are split into two beats; 0 = they are errored.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  pipeline access request.
- `req_ready`  out  1  high only in IDLE; request accepted when `req_valid && req_ready`.
- `req_wr`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  byte address.
- `req_size`  in  2  0 = B, 1 = H, 2 = W, 3 = D; n = 1<<size bytes.
- `req_unsigned`  in  1  zero-extend load (LBU/LHU/LWU).
- `req_wdata`  in  64  store data, right-justified.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  64  extended load data; 0 for stores and errors.
- `resp_err`  out  1  valid with `resp_valid`; access not performed.
- `bus_valid`  out  1  beat request.
- `bus_ready`  in  1  beat accepted when `bus_valid && bus_ready`.
- `bus_wr`  out  1  beat is a write.
- `bus_addr`  out  ADDR_W  NB-aligned beat address.
- `bus_wdata`  out  DATA_W  lane-shifted write data.
- `bus_wstrb`  out  NB  byte strobes.
- `bus_rvalid`  in  1  read data return, at least 1 cycle after read beat accept; in order.
- `bus_rdata`  in  DATA_W  read data.

## Operation
- FSM states: IDLE, B0 (beat 0 issued), R0 (await rvalid 0), B1, R1, RESP.
- All request fields are latched at accept. Let o = addr mod NB, n = 1<<size, split = (o+n > NB).
- Error: if n > NB, or split && !ALLOW_MISALIGN, then IDLE→RESP with `resp_err`=1. There is no bus activity.
- Beat 0: addr = addr & ~(NB-1), wstrb = (((1<<n)-1)<<o) truncated to NB bits, wdata = wdata<<(8o).
- Beat 1, issued only if split: addr = beat0 addr + NB, wstrb = ((1<<n)-1)>>(NB-o), wdata = wdata>>(8(NB-o)).
- Transitions:
  - B0 accept: a write goes to B1 if split, else RESP. A read goes to R0.
  - R0 rvalid: capture lo; go to B1 if split, else RESP.
  - B1 accept: a write goes to RESP; a read goes to R1.
  - R1 rvalid: capture hi; go to RESP.
  - RESP: go to IDLE.
- Load merge: raw = (lo>>8o) | (hi<<8(NB-o)), taken mod 2^(8n). The result is sign-extended to 64 bits unless `req_unsigned`. For D loads on DATA_W=64 the result is raw.
- `bus_valid`, `bus_wr`, `bus_addr`, `bus_wdata` and `bus_wstrb` are held stable until accept (AXI-like).
- `bus_rvalid` outside R0/R1 is ignored.

## Timing
- Reset (`rst`=0), asynchronous: state goes to IDLE and all registered outputs go to 0. `req_ready`=1 combinationally, but requests are ignored while `rst`=0. Reset mid-transfer abandons the access with no response; the bus slave must also be reset.
- Request accepted in cycle T: `bus_valid` goes high at T+1 (registered), and `req_ready` is low from T+1 until the cycle after RESP.
- Aligned store with `bus_ready`=1: beat accepted at T+1, `resp_valid` at T+2.
- Aligned load with `bus_ready`=1 and rvalid one cycle after accept: `resp_valid` at T+3.
- Split load: `resp_valid` at T+5. Split store: `resp_valid` at T+3.
- Error: `resp_valid`/`resp_err` at T+1.
- `resp_valid` lasts exactly 1 cycle. The next request can be accepted in the cycle after RESP.
- Each `bus_ready` stall cycle adds one cycle of latency.

## Test plan
- DATA_W=64, LD 0x1000 (D), rdata 0x8877665544332211 → bus_addr 0x1000, wstrb 0x00 (read), resp_rdata 0x8877665544332211 at T+3.
- SW 0x1006, wdata 0xAABBCCDD → beat0 addr 0x1000, wstrb 0xC0, wdata 0xCCDD000000000000; beat1 addr 0x1008, wstrb 0x03, wdata low 16 bits 0xAABB; resp at T+3.
- LW signed 0x2006, lo 0x1122334455667788, hi 0x99AABBCCDDEEFF00 → resp_rdata 0xFFFFFFFFFF001122. Same access as LWU → 0x00000000FF001122.
- ALLOW_MISALIGN=0, LH 0x3007 → resp_err=1 at T+1, bus_valid never asserted. DATA_W=32, LD 0x0 → resp_err=1.
- SB 0x4003, wdata 0x5A, bus_ready held low 3 cycles → bus_addr, wstrb 0x08 and wdata stable throughout; resp_valid one cycle after accept.
- Assert `rst`=0 while in R0 → outputs 0 immediately. After release, a new aligned LD completes normally, and a stray `bus_rvalid` arriving in IDLE is ignored.

Source files
------------

// File: rtl/mem_split_lsu_if.sv
// Bus-side beat interface of the memory-stage LSU: valid/ready write/read
// beats plus in-order read-data return.
interface mem_split_lsu_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    logic                  bus_valid;
    logic                  bus_ready;
    logic                  bus_wr;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W/8-1:0]   bus_wstrb;
    logic                  bus_rvalid;
    logic [DATA_W-1:0]     bus_rdata;

    modport master (
        output bus_valid, bus_wr, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_wr, bus_addr, bus_wdata, bus_wstrb,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/mem_split_lsu.sv
// RV64 memory-stage load/store unit. Aligns byte lanes, builds write strobes,
// sign/zero-extends loads and splits bus-word-crossing accesses into two beats.
module mem_split_lsu #(
    parameter int DATA_W         = 64,
    parameter int ADDR_W         = 64,
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    mem_split_lsu_if.master   bus
);
    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);
    localparam logic [4:0]      NB5       = 5'(NB);
    localparam logic [2*NB-1:0] ONE_M     = 1;
    localparam logic [6:0]      BEAT_BITS = 7'(DATA_W);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] B0   = 3'd1;
    localparam logic [2:0] R0   = 3'd2;
    localparam logic [2:0] B1   = 3'd3;
    localparam logic [2:0] R1   = 3'd4;
    localparam logic [2:0] RESP = 3'd5;

    logic [2:0]        state_q, state_d;
    logic              wr_q, wr_d, uns_q, uns_d, split_q, split_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              bus_valid_q, bus_valid_d, bus_wr_q, bus_wr_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [NB-1:0]     bus_wstrb_q, bus_wstrb_d;
    logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [63:0]       resp_rdata_q, resp_rdata_d;

    logic              idle;
    logic              s_wr;
    logic [1:0]        s_size;
    logic [ADDR_W-1:0] s_addr;
    logic [63:0]       s_wdata;
    logic [OW-1:0]     off;
    logic [3:0]        nbytes;
    logic [4:0]        end_b;
    logic              s_split, s_err;
    logic [2*NB-1:0]   mask;
    logic [6:0]        sh_lo, sh_hi;
    logic [ADDR_W-1:0] b0_addr, b1_addr;
    logic [DATA_W-1:0] b0_wdata, b1_wdata;
    logic [DATA_W-1:0] lo_src, hi_src;
    logic [63:0]       raw, ext;

    assign idle = (state_q == IDLE);

    // Beat geometry: from the live request while idle (beat 0 is built at
    // accept), otherwise from the latched request.
    always_comb begin
        s_wr     = idle ? req_wr    : wr_q;
        s_size   = idle ? req_size  : size_q;
        s_addr   = idle ? req_addr  : addr_q;
        s_wdata  = idle ? req_wdata : wdata_q;
        off      = s_addr[OW-1:0];
        nbytes   = 4'd1 << s_size;
        end_b    = 5'(off) + 5'(nbytes);
        s_split  = end_b > NB5;
        s_err    = (5'(nbytes) > NB5) || (s_split && !ALLOW_MISALIGN);
        // Low half of the double-width mask is beat 0, high half is beat 1.
        mask     = ((ONE_M << nbytes) - ONE_M) << off;
        sh_lo    = 7'({off, 3'b000});
        sh_hi    = BEAT_BITS - sh_lo;
        b0_addr  = {s_addr[ADDR_W-1:OW], {OW{1'b0}}};
        b1_addr  = b0_addr + ADDR_W'(NB);
        b0_wdata = DATA_W'(s_wdata << sh_lo);
        b1_wdata = DATA_W'(s_wdata >> sh_hi);
    end

    // Load merge: the returning beat is taken straight off the bus so the
    // result can be registered in the same cycle rvalid arrives.
    always_comb begin
        lo_src = (state_q == R0) ? bus.bus_rdata : lo_q;
        hi_src = (state_q == R1) ? bus.bus_rdata : '0;
        raw    = (64'(lo_src) >> sh_lo) | (64'(hi_src) << sh_hi);
        case (size_q)
            2'd0:    ext = {{56{~uns_q & raw[7]}},  raw[7:0]};
            2'd1:    ext = {{48{~uns_q & raw[15]}}, raw[15:0]};
            2'd2:    ext = {{32{~uns_q & raw[31]}}, raw[31:0]};
            default: ext = raw;
        endcase
    end

    // Access sequencer: request latch, beat issue, read capture, response.
    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        uns_d        = uns_q;
        split_d      = split_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
        bus_valid_d  = bus_valid_q;
        bus_wr_d     = bus_wr_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wstrb_d  = bus_wstrb_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        case (state_q)
            IDLE: if (req_valid) begin
                wr_d    = req_wr;
                uns_d   = req_unsigned;
                size_d  = req_size;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                split_d = s_split;
                if (s_err) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    state_d     = B0;
                    bus_valid_d = 1'b1;
                    bus_wr_d    = s_wr;
                    bus_addr_d  = b0_addr;
                    bus_wdata_d = s_wr ? b0_wdata : '0;
                    bus_wstrb_d = s_wr ? mask[NB-1:0] : '0;
                end
            end
            B0: if (bus.bus_ready) begin
                if (wr_q && split_q) begin
                    state_d     = B1;
                    bus_addr_d  = b1_addr;
                    bus_wdata_d = b1_wdata;
                    bus_wstrb_d = mask[2*NB-1:NB];
                end else begin
                    state_d      = wr_q ? RESP : R0;
                    resp_valid_d = wr_q;
                    bus_valid_d  = 1'b0;
                    bus_wr_d     = 1'b0;
                    bus_addr_d   = '0;
                    bus_wdata_d  = '0;
                    bus_wstrb_d  = '0;
                end
            end
            R0: if (bus.bus_rvalid) begin
                lo_d = bus.bus_rdata;
                if (split_q) begin
                    state_d     = B1;
                    bus_valid_d = 1'b1;
                    bus_addr_d  = b1_addr;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ext;
                end
            end
            B1: if (bus.bus_ready) begin
                state_d      = wr_q ? RESP : R1;
                resp_valid_d = wr_q;
                bus_valid_d  = 1'b0;
                bus_wr_d     = 1'b0;
                bus_addr_d   = '0;
                bus_wdata_d  = '0;
                bus_wstrb_d  = '0;
            end
            R1: if (bus.bus_rvalid) begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = ext;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wr_q         <= 1'b0;
            uns_q        <= 1'b0;
            split_q      <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lo_q         <= '0;
            bus_valid_q  <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_wstrb_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            uns_q        <= uns_d;
            split_q      <= split_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lo_q         <= lo_d;
            bus_valid_q  <= bus_valid_d;
            bus_wr_q     <= bus_wr_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wstrb_q  <= bus_wstrb_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready     = idle;
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign resp_rdata    = resp_rdata_q;
    assign bus.bus_valid = bus_valid_q;
    assign bus.bus_wr    = bus_wr_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.bus_wstrb = bus_wstrb_q;
endmodule

// File: tb/tb_mem_split_lsu.sv
// Directed bench for mem_split_lsu: a 64-bit misalign-capable unit (a),
// a 64-bit unit with misalign disabled (b) and a 32-bit unit (c).
module tb_mem_split_lsu;
    logic        clk;
    logic        rst;
    logic        req_valid_a, req_valid_b, req_valid_c;
    logic        req_wr;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic        req_ready_a, req_ready_b, req_ready_c;
    logic        resp_valid_a, resp_valid_b, resp_valid_c;
    logic [63:0] resp_rdata_a, resp_rdata_b, resp_rdata_c;
    logic        resp_err_a, resp_err_b, resp_err_c;
    int          nchk;
    int          nfail;

    mem_split_lsu_if #(.DATA_W(64), .ADDR_W(64)) bif_a ();
    mem_split_lsu_if #(.DATA_W(64), .ADDR_W(64)) bif_b ();
    mem_split_lsu_if #(.DATA_W(32), .ADDR_W(64)) bif_c ();

    mem_split_lsu #(.DATA_W(64), .ADDR_W(64), .ALLOW_MISALIGN(1'b1)) u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_wr(req_wr), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a), .resp_err(resp_err_a),
        .bus(bif_a)
    );
    mem_split_lsu #(.DATA_W(64), .ADDR_W(64), .ALLOW_MISALIGN(1'b0)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_wr(req_wr), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
        .bus(bif_b)
    );
    mem_split_lsu #(.DATA_W(32), .ADDR_W(64), .ALLOW_MISALIGN(1'b1)) u_c (
        .clk(clk), .rst(rst), .req_valid(req_valid_c), .req_ready(req_ready_c),
        .req_wr(req_wr), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(resp_valid_c), .resp_rdata(resp_rdata_c), .resp_err(resp_err_c),
        .bus(bif_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge: inputs are driven and
    // outputs sampled here, well clear of the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic wr, input logic [63:0] addr, input logic [1:0] size,
                           input logic uns, input logic [63:0] wdata);
        req_wr = wr; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_req(1'b0, 64'h1000, 2'd3, 1'b0, 64'h0);
        req_valid_a = 1'b1;
        step(); step(); step();
        nchk++; if (req_ready_a !== 1'b1) begin nfail++; $display("FAIL rst_req_ready: got %b want 1", req_ready_a); end
        nchk++; if (bif_a.bus_valid !== 1'b0) begin nfail++; $display("FAIL rst_bus_valid: got %b want 0", bif_a.bus_valid); end
        nchk++; if (resp_valid_a !== 1'b0 || resp_rdata_a !== 64'h0) begin nfail++; $display("FAIL rst_resp: got v=%b d=%h want 0", resp_valid_a, resp_rdata_a); end
        nchk++; if (bif_a.bus_addr !== 64'h0 || bif_a.bus_wstrb !== 8'h0) begin nfail++; $display("FAIL rst_bus_fields: got a=%h s=%h want 0", bif_a.bus_addr, bif_a.bus_wstrb); end
        req_valid_a = 1'b0;
        rst = 1'b1;
        step();
        nchk++; if (bif_a.bus_valid !== 1'b0) begin nfail++; $display("FAIL rst_ignored_req: got bus_valid=%b want 0", bif_a.bus_valid); end
    endtask

    task automatic test_aligned_load();
        // LD 0x1000
        set_req(1'b0, 64'h1000, 2'd3, 1'b0, 64'h0);
        req_valid_a = 1'b1;
        nchk++; if (req_ready_a !== 1'b1) begin nfail++; $display("FAIL ld_ready_T: got %b want 1", req_ready_a); end
        step(); req_valid_a = 1'b0;
        nchk++; if (bif_a.bus_valid !== 1'b1 || bif_a.bus_wr !== 1'b0) begin nfail++; $display("FAIL ld_beat: got v=%b wr=%b want v=1 wr=0", bif_a.bus_valid, bif_a.bus_wr); end
        nchk++; if (bif_a.bus_addr !== 64'h1000 || bif_a.bus_wstrb !== 8'h00) begin nfail++; $display("FAIL ld_addr_strb: got a=%h s=%h want 1000/00", bif_a.bus_addr, bif_a.bus_wstrb); end
        nchk++; if (req_ready_a !== 1'b0) begin nfail++; $display("FAIL ld_ready_T1: got %b want 0", req_ready_a); end
        step();
        nchk++; if (bif_a.bus_valid !== 1'b0 || resp_valid_a !== 1'b0) begin nfail++; $display("FAIL ld_T2: got bv=%b rv=%b want 0/0", bif_a.bus_valid, resp_valid_a); end
        bif_a.bus_rvalid = 1'b1; bif_a.bus_rdata = 64'h8877665544332211;
        step(); bif_a.bus_rvalid = 1'b0;
        nchk++; if (resp_valid_a !== 1'b1 || resp_err_a !== 1'b0) begin nfail++; $display("FAIL ld_resp_T3: got v=%b e=%b want 1/0", resp_valid_a, resp_err_a); end
        nchk++; if (resp_rdata_a !== 64'h8877665544332211) begin nfail++; $display("FAIL ld_rdata: got %h want 8877665544332211", resp_rdata_a); end
        step();
        nchk++; if (resp_valid_a !== 1'b0 || req_ready_a !== 1'b1) begin nfail++; $display("FAIL ld_T4: got rv=%b rdy=%b want 0/1", resp_valid_a, req_ready_a); end
        // LB 0x5005, byte 0x80 -> sign extended
        set_req(1'b0, 64'h5005, 2'd0, 1'b0, 64'h0);
        req_valid_a = 1'b1;
        step(); req_valid_a = 1'b0;
        nchk++; if (bif_a.bus_addr !== 64'h5000) begin nfail++; $display("FAIL lb_addr: got %h want 5000", bif_a.bus_addr); end
        step();
        bif_a.bus_rvalid = 1'b1; bif_a.bus_rdata = 64'h0000800000000000;
        step(); bif_a.bus_rvalid = 1'b0;
        nchk++; if (resp_valid_a !== 1'b1 || resp_rdata_a !== 64'hFFFFFFFFFFFFFF80) begin nfail++; $display("FAIL lb_rdata: got v=%b d=%h want 1/ffffffffffffff80", resp_valid_a, resp_rdata_a); end
        step();
    endtask

    task automatic test_split_store();
        set_req(1'b1, 64'h1006, 2'd2, 1'b0, 64'hAABBCCDD);
        req_valid_a = 1'b1;
        step(); req_valid_a = 1'b0;
        nchk++; if (bif_a.bus_valid !== 1'b1 || bif_a.bus_wr !== 1'b1 || bif_a.bus_addr !== 64'h1000) begin nfail++; $display("FAIL sw_b0_addr: got v=%b wr=%b a=%h want 1/1/1000", bif_a.bus_valid, bif_a.bus_wr, bif_a.bus_addr); end
        nchk++; if (bif_a.bus_wstrb !== 8'hC0 || bif_a.bus_wdata !== 64'hCCDD000000000000) begin nfail++; $display("FAIL sw_b0_data: got s=%h d=%h want c0/ccdd000000000000", bif_a.bus_wstrb, bif_a.bus_wdata); end
        step();
        nchk++; if (bif_a.bus_valid !== 1'b1 || bif_a.bus_addr !== 64'h1008 || bif_a.bus_wstrb !== 8'h03) begin nfail++; $display("FAIL sw_b1: got v=%b a=%h s=%h want 1/1008/03", bif_a.bus_valid, bif_a.bus_addr, bif_a.bus_wstrb); end
        nchk++; if (bif_a.bus_wdata[15:0] !== 16'hAABB || resp_valid_a !== 1'b0) begin nfail++; $display("FAIL sw_b1_data: got d=%h rv=%b want aabb/0", bif_a.bus_wdata[15:0], resp_valid_a); end
        step();
        nchk++; if (resp_valid_a !== 1'b1 || resp_err_a !== 1'b0 || resp_rdata_a !== 64'h0) begin nfail++; $display("FAIL sw_resp_T3: got v=%b e=%b d=%h want 1/0/0", resp_valid_a, resp_err_a, resp_rdata_a); end
        nchk++; if (bif_a.bus_valid !== 1'b0) begin nfail++; $display("FAIL sw_bus_idle: got %b want 0", bif_a.bus_valid); end
        step();
    endtask

    task automatic test_split_load();
        for (int u = 0; u < 2; u++) begin
            set_req(1'b0, 64'h2006, 2'd2, (u == 1), 64'h0);
            req_valid_a = 1'b1;
            step(); req_valid_a = 1'b0;
            nchk++; if (bif_a.bus_addr !== 64'h2000 || bif_a.bus_valid !== 1'b1) begin nfail++; $display("FAIL lw_b0: got v=%b a=%h want 1/2000", bif_a.bus_valid, bif_a.bus_addr); end
            step();
            bif_a.bus_rvalid = 1'b1; bif_a.bus_rdata = 64'h1122334455667788;
            step(); bif_a.bus_rvalid = 1'b0;
            nchk++; if (bif_a.bus_valid !== 1'b1 || bif_a.bus_addr !== 64'h2008 || bif_a.bus_wstrb !== 8'h00) begin nfail++; $display("FAIL lw_b1: got v=%b a=%h s=%h want 1/2008/00", bif_a.bus_valid, bif_a.bus_addr, bif_a.bus_wstrb); end
            step();
            nchk++; if (resp_valid_a !== 1'b0) begin nfail++; $display("FAIL lw_T4: got rv=%b want 0", resp_valid_a); end
            bif_a.bus_rvalid = 1'b1; bif_a.bus_rdata = 64'h99AABBCCDDEEFF00;
            step(); bif_a.bus_rvalid = 1'b0;
            if (u == 0) begin
                nchk++; if (resp_valid_a !== 1'b1 || resp_rdata_a !== 64'hFFFFFFFFFF001122) begin nfail++; $display("FAIL lw_signed: got v=%b d=%h want 1/ffffffffff001122", resp_valid_a, resp_rdata_a); end
            end else begin
                nchk++; if (resp_valid_a !== 1'b1 || resp_rdata_a !== 64'h00000000FF001122) begin nfail++; $display("FAIL lwu: got v=%b d=%h want 1/00000000ff001122", resp_valid_a, resp_rdata_a); end
            end
            step();
        end
    endtask

    task automatic test_errors();
        // LH 0x3007 crosses the word on the no-misalign unit
        set_req(1'b0, 64'h3007, 2'd1, 1'b0, 64'h0);
        req_valid_b = 1'b1;
        step(); req_valid_b = 1'b0;
        nchk++; if (resp_valid_b !== 1'b1 || resp_err_b !== 1'b1 || resp_rdata_b !== 64'h0) begin nfail++; $display("FAIL err_mis_resp: got v=%b e=%b d=%h want 1/1/0", resp_valid_b, resp_err_b, resp_rdata_b); end
        nchk++; if (bif_b.bus_valid !== 1'b0) begin nfail++; $display("FAIL err_mis_bus_T1: got %b want 0", bif_b.bus_valid); end
        step();
        nchk++; if (resp_valid_b !== 1'b0 || bif_b.bus_valid !== 1'b0 || req_ready_b !== 1'b1) begin nfail++; $display("FAIL err_mis_T2: got rv=%b bv=%b rdy=%b want 0/0/1", resp_valid_b, bif_b.bus_valid, req_ready_b); end
        // LD on the 32-bit unit is wider than a beat
        set_req(1'b0, 64'h0, 2'd3, 1'b0, 64'h0);
        req_valid_c = 1'b1;
        step(); req_valid_c = 1'b0;
        nchk++; if (resp_valid_c !== 1'b1 || resp_err_c !== 1'b1 || bif_c.bus_valid !== 1'b0) begin nfail++; $display("FAIL err_wide: got v=%b e=%b bv=%b want 1/1/0", resp_valid_c, resp_err_c, bif_c.bus_valid); end
        step();
    endtask

    task automatic test_store_stall();
        set_req(1'b1, 64'h4003, 2'd0, 1'b0, 64'h5A);
        bif_a.bus_ready = 1'b0;
        req_valid_a = 1'b1;
        step(); req_valid_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nchk++; if (bif_a.bus_valid !== 1'b1 || bif_a.bus_addr !== 64'h4000 || bif_a.bus_wstrb !== 8'h08 || bif_a.bus_wdata !== 64'h000000005A000000) begin nfail++; $display("FAIL sb_stall_hold[%0d]: got v=%b a=%h s=%h d=%h want 1/4000/08/5a000000", i, bif_a.bus_valid, bif_a.bus_addr, bif_a.bus_wstrb, bif_a.bus_wdata); end
            nchk++; if (resp_valid_a !== 1'b0) begin nfail++; $display("FAIL sb_stall_resp[%0d]: got %b want 0", i, resp_valid_a); end
            if (i == 3) bif_a.bus_ready = 1'b1;
            step();
        end
        nchk++; if (resp_valid_a !== 1'b1 || bif_a.bus_valid !== 1'b0) begin nfail++; $display("FAIL sb_resp: got rv=%b bv=%b want 1/0", resp_valid_a, bif_a.bus_valid); end
        step();
        nchk++; if (resp_valid_a !== 1'b0) begin nfail++; $display("FAIL sb_pulse: got %b want 0", resp_valid_a); end
    endtask

    task automatic test_back_to_back();
        set_req(1'b1, 64'h1010, 2'd3, 1'b0, 64'h1122334455667788);
        req_valid_a = 1'b1;
        step(); req_valid_a = 1'b0;
        nchk++; if (bif_a.bus_wstrb !== 8'hFF || bif_a.bus_wdata !== 64'h1122334455667788) begin nfail++; $display("FAIL sd_beat: got s=%h d=%h want ff/1122334455667788", bif_a.bus_wstrb, bif_a.bus_wdata); end
        step();
        nchk++; if (resp_valid_a !== 1'b1 || req_ready_a !== 1'b0) begin nfail++; $display("FAIL sd_resp_T2: got rv=%b rdy=%b want 1/0", resp_valid_a, req_ready_a); end
        step();
        nchk++; if (req_ready_a !== 1'b1) begin nfail++; $display("FAIL b2b_ready: got %b want 1", req_ready_a); end
        set_req(1'b1, 64'h1012, 2'd1, 1'b0, 64'hBEEF);
        req_valid_a = 1'b1;
        step(); req_valid_a = 1'b0;
        nchk++; if (bif_a.bus_addr !== 64'h1010 || bif_a.bus_wstrb !== 8'h0C || bif_a.bus_wdata !== 64'h00000000BEEF0000) begin nfail++; $display("FAIL sh_beat: got a=%h s=%h d=%h want 1010/0c/beef0000", bif_a.bus_addr, bif_a.bus_wstrb, bif_a.bus_wdata); end
        step();
        nchk++; if (resp_valid_a !== 1'b1) begin nfail++; $display("FAIL sh_resp: got %b want 1", resp_valid_a); end
        step();
    endtask

    task automatic test_reset_mid();
        set_req(1'b0, 64'h1000, 2'd3, 1'b0, 64'h0);
        req_valid_a = 1'b1;
        step(); req_valid_a = 1'b0;
        step();
        nchk++; if (req_ready_a !== 1'b0) begin nfail++; $display("FAIL mid_in_r0: got rdy=%b want 0", req_ready_a); end
        #2 rst = 1'b0;
        #1;
        nchk++; if (req_ready_a !== 1'b1 || bif_a.bus_valid !== 1'b0 || resp_valid_a !== 1'b0) begin nfail++; $display("FAIL mid_async_rst: got rdy=%b bv=%b rv=%b want 1/0/0", req_ready_a, bif_a.bus_valid, resp_valid_a); end
        step(); step();
        rst = 1'b1;
        step();
        // stray read data while idle
        bif_a.bus_rvalid = 1'b1; bif_a.bus_rdata = 64'hDEADBEEFDEADBEEF;
        step(); bif_a.bus_rvalid = 1'b0;
        nchk++; if (resp_valid_a !== 1'b0 || req_ready_a !== 1'b1) begin nfail++; $display("FAIL stray_rvalid: got rv=%b rdy=%b want 0/1", resp_valid_a, req_ready_a); end
        req_valid_a = 1'b1;
        step(); req_valid_a = 1'b0;
        nchk++; if (bif_a.bus_valid !== 1'b1 || bif_a.bus_addr !== 64'h1000) begin nfail++; $display("FAIL post_rst_beat: got v=%b a=%h want 1/1000", bif_a.bus_valid, bif_a.bus_addr); end
        step();
        bif_a.bus_rvalid = 1'b1; bif_a.bus_rdata = 64'h0123456789ABCDEF;
        step(); bif_a.bus_rvalid = 1'b0;
        nchk++; if (resp_valid_a !== 1'b1 || resp_rdata_a !== 64'h0123456789ABCDEF) begin nfail++; $display("FAIL post_rst_ld: got v=%b d=%h want 1/0123456789abcdef", resp_valid_a, resp_rdata_a); end
        step();
    endtask

    initial begin
        nchk = 0; nfail = 0;
        req_valid_a = 1'b0; req_valid_b = 1'b0; req_valid_c = 1'b0;
        set_req(1'b0, 64'h0, 2'd0, 1'b0, 64'h0);
        bif_a.bus_ready = 1'b1; bif_a.bus_rvalid = 1'b0; bif_a.bus_rdata = 64'h0;
        bif_b.bus_ready = 1'b1; bif_b.bus_rvalid = 1'b0; bif_b.bus_rdata = 64'h0;
        bif_c.bus_ready = 1'b1; bif_c.bus_rvalid = 1'b0; bif_c.bus_rdata = 32'h0;
        test_reset();
        test_aligned_load();
        test_split_store();
        test_split_load();
        test_errors();
        test_store_stall();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
